request_unit: RTL and testbench

REQUEST_UNIT -- requirements
Module: request_unit

---
 rtl/cpu_types_pkg.sv | 14 +
 rtl/request_unit_if.sv | 28 ++
 rtl/sat_counter.sv | 29 ++
 rtl/request_unit.sv | 123 ++++++++++++
 tb/tb_request_unit.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: request-unit state encoding and stall-counter width.
package cpu_types_pkg;

    // Width of the memory stall performance counters
    localparam int STALL_CNT_W = 16;

    // Memory request arbitration states
    typedef enum logic [1:0] {
        FETCH  = 2'b00,
        DATA   = 2'b01,
        HALTED = 2'b10
    } reqstate_t;

endpackage

// File: rtl/request_unit_if.sv
// Request unit interface bundle: ru side is the block, tb side drives it.
interface request_unit_if;
    import cpu_types_pkg::*;

    logic                   ihit;
    logic                   dhit;
    logic                   mem_dREN;
    logic                   mem_dWEN;
    logic                   mem_halt;
    logic                   mem_advance;
    logic                   imemREN;
    logic                   dmemREN;
    logic                   dmemWEN;
    logic                   halt;
    logic [STALL_CNT_W-1:0] dstall_cnt;
    logic [STALL_CNT_W-1:0] istall_cnt;

    modport ru (
        input  ihit, dhit, mem_dREN, mem_dWEN, mem_halt, mem_advance,
        output imemREN, dmemREN, dmemWEN, halt, dstall_cnt, istall_cnt
    );

    modport tb (
        output ihit, dhit, mem_dREN, mem_dWEN, mem_halt, mem_advance,
        input  imemREN, dmemREN, dmemWEN, halt, dstall_cnt, istall_cnt
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc high, sticks at all-ones.
module sat_counter #(
    parameter int width = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    output logic [width-1:0] count
);

    localparam logic [width-1:0] CNT_MAX = {width{1'b1}};
    localparam logic [width-1:0] CNT_ONE = {{(width-1){1'b0}}, 1'b1};

    logic [width-1:0] count_r;

    // Count register: increments on inc, never wraps past all-ones
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_r <= {width{1'b0}};
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/request_unit.sv
// Memory request arbiter: instruction fetch vs. data access, with halt
// handling, single-issue protection for data ops and stall counters.
module request_unit
    import cpu_types_pkg::*;
(
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   ihit,
    input  logic                   dhit,
    input  logic                   mem_dREN,
    input  logic                   mem_dWEN,
    input  logic                   mem_halt,
    input  logic                   mem_advance,
    output logic                   imemREN,
    output logic                   dmemREN,
    output logic                   dmemWEN,
    output logic                   halt,
    output logic [STALL_CNT_W-1:0] dstall_cnt,
    output logic [STALL_CNT_W-1:0] istall_cnt
);

    reqstate_t state_r;
    reqstate_t next_state_s;
    logic      served_r;
    logic      halt_r;
    logic      imem_ren_s;
    logic      dmem_ren_s;
    logic      dmem_wen_s;
    logic      dstall_inc_s;
    logic      istall_inc_s;

    // State register; reset returns to FETCH immediately, dropping any data request
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and request outputs; a pending data op outranks fetch and halt
    always_comb begin
        next_state_s = state_r;
        imem_ren_s   = 1'b0;
        dmem_ren_s   = 1'b0;
        dmem_wen_s   = 1'b0;
        case (state_r)
            FETCH: begin
                imem_ren_s = 1'b1;
                if ((mem_dREN || mem_dWEN) && !served_r) begin
                    next_state_s = DATA;
                end else if (mem_halt) begin
                    next_state_s = HALTED;
                end else begin
                    next_state_s = FETCH;
                end
            end
            DATA: begin
                // A load+store combination is issued as a store only
                dmem_wen_s = mem_dWEN;
                dmem_ren_s = mem_dREN & ~mem_dWEN;
                if (dhit) begin
                    next_state_s = FETCH;
                end else begin
                    next_state_s = DATA;
                end
            end
            HALTED: begin
                next_state_s = HALTED;
            end
            default: begin
                next_state_s = FETCH;
            end
        endcase
    end

    // Served flag: blocks re-issue of a completed op until the EX/MEM latch moves on
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            served_r <= 1'b0;
        end else if (mem_advance) begin
            served_r <= 1'b0;
        end else if ((state_r == DATA) && dhit) begin
            served_r <= 1'b1;
        end else begin
            served_r <= served_r;
        end
    end

    // Sticky halt flag, set on the edge that enters HALTED
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            halt_r <= 1'b0;
        end else if (next_state_s == HALTED) begin
            halt_r <= 1'b1;
        end else begin
            halt_r <= halt_r;
        end
    end

    assign dstall_inc_s = (state_r == DATA) && !dhit;
    assign istall_inc_s = imem_ren_s && !ihit;

    sat_counter #(.width(STALL_CNT_W)) u_dstall (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (dstall_inc_s),
        .count (dstall_cnt)
    );

    sat_counter #(.width(STALL_CNT_W)) u_istall (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (istall_inc_s),
        .count (istall_cnt)
    );

    assign imemREN = imem_ren_s;
    assign dmemREN = dmem_ren_s;
    assign dmemWEN = dmem_wen_s;
    assign halt    = halt_r;

endmodule

// File: tb/tb_request_unit.sv
// Scoreboard bench for request_unit: stimulus pushes expected outputs,
// a monitor pops and compares them at the falling edge.
module tb_request_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit, dhit, mem_dREN, mem_dWEN, mem_halt, mem_advance;
    logic        imemREN, dmemREN, dmemWEN, halt;
    logic [15:0] dstall_cnt, istall_cnt;

    typedef struct {
        string       tag;
        logic        im;
        logic        dr;
        logic        dw;
        logic        h;
        logic [15:0] dc;
        logic [15:0] ic;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   done = 1'b0;
    event async_ev;

    request_unit dut (
        .CLK         (CLK),
        .RST         (RST),
        .ihit        (ihit),
        .dhit        (dhit),
        .mem_dREN    (mem_dREN),
        .mem_dWEN    (mem_dWEN),
        .mem_halt    (mem_halt),
        .mem_advance (mem_advance),
        .imemREN     (imemREN),
        .dmemREN     (dmemREN),
        .dmemWEN     (dmemWEN),
        .halt        (halt),
        .dstall_cnt  (dstall_cnt),
        .istall_cnt  (istall_cnt)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 CLK = ~CLK;

    task automatic drive(input logic ih, input logic dh, input logic dr,
                         input logic dw, input logic mh, input logic adv);
        ihit        = ih;
        dhit        = dh;
        mem_dREN    = dr;
        mem_dWEN    = dw;
        mem_halt    = mh;
        mem_advance = adv;
    endtask

    task automatic expect_out(input string tag, input logic im, input logic dr,
                              input logic dw, input logic h,
                              input logic [15:0] dc, input logic [15:0] ic);
        exp_t e;
        e.tag = tag; e.im = im; e.dr = dr; e.dw = dw; e.h = h; e.dc = dc; e.ic = ic;
        q.push_back(e);
    endtask

    // One cycle: drive inputs, queue expected outputs for this cycle, advance
    task automatic cyc(input string tag,
                       input logic ih, input logic dh, input logic dr,
                       input logic dw, input logic mh, input logic adv,
                       input logic eim, input logic edr, input logic edw,
                       input logic eh, input logic [15:0] edc, input logic [15:0] eic);
        drive(ih, dh, dr, dw, mh, adv);
        expect_out(tag, eim, edr, edw, eh, edc, eic);
        @(posedge CLK);
        #1;
    endtask

    // Monitor: compares queued expectations against the DUT outputs
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK or async_ev);
            while (q.size() > 0) begin
                e = q.pop_front();
                n_checks++;
                if ({imemREN, dmemREN, dmemWEN, halt} !== {e.im, e.dr, e.dw, e.h}) begin
                    n_errors++;
                    $display("FAIL %s: got imemREN=%b dmemREN=%b dmemWEN=%b halt=%b, expected %b %b %b %b",
                             e.tag, imemREN, dmemREN, dmemWEN, halt,
                             e.im, e.dr, e.dw, e.h);
                end
                if (dstall_cnt !== e.dc) begin
                    n_errors++;
                    $display("FAIL %s: got dstall=%h, expected %h", e.tag, dstall_cnt, e.dc);
                end
                if (istall_cnt !== e.ic) begin
                    n_errors++;
                    $display("FAIL %s: got istall=%h, expected %h", e.tag, istall_cnt, e.ic);
                end
            end
            if (done) begin
                $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
                $finish;
            end
        end
    end

    // Watchdog so the run always terminates
    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    // Directed stimulus
    initial begin : stimulus
        logic [5:0] r;
        RST = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #12;
        expect_out("in_reset", 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Reset release with ihit high
        cyc("idle",        1,0,0,0,0,0, 1,0,0,0, 16'd0, 16'd0);

        // Load with three wait cycles; ihit during DATA must be ignored
        cyc("ld_req",      1,0,1,0,0,0, 1,0,0,0, 16'd0, 16'd0);
        cyc("ld_wait1",    1,0,1,0,0,0, 0,1,0,0, 16'd0, 16'd0);
        cyc("ld_wait2",    1,0,1,0,0,0, 0,1,0,0, 16'd1, 16'd0);
        cyc("ld_wait3",    1,0,1,0,0,0, 0,1,0,0, 16'd2, 16'd0);
        cyc("ld_hit",      1,1,1,0,0,0, 0,1,0,0, 16'd3, 16'd0);
        cyc("ld_served1",  1,0,1,0,0,0, 1,0,0,0, 16'd3, 16'd0);
        cyc("ld_served2",  1,0,1,0,0,0, 1,0,0,0, 16'd3, 16'd0);
        cyc("ld_adv",      1,0,0,0,0,1, 1,0,0,0, 16'd3, 16'd0);

        // dhit and advance together: the following load is requested again
        cyc("b2b_req",     1,0,1,0,0,0, 1,0,0,0, 16'd3, 16'd0);
        cyc("b2b_hit_adv", 1,1,1,0,0,1, 0,1,0,0, 16'd3, 16'd0);
        cyc("b2b_req2",    1,0,1,0,0,0, 1,0,0,0, 16'd3, 16'd0);
        cyc("b2b_data2",   1,0,1,0,0,0, 0,1,0,0, 16'd3, 16'd0);
        cyc("b2b_hit2",    1,1,1,0,0,1, 0,1,0,0, 16'd4, 16'd0);

        // Fetch stalls
        cyc("istall1",     0,0,0,0,0,0, 1,0,0,0, 16'd4, 16'd0);
        cyc("istall2",     0,0,0,0,0,0, 1,0,0,0, 16'd4, 16'd1);
        cyc("istall3",     1,0,0,0,0,0, 1,0,0,0, 16'd4, 16'd2);

        // Load and store together is issued as a store only
        cyc("rw_req",      1,0,1,1,0,0, 1,0,0,0, 16'd4, 16'd2);
        cyc("rw_hit",      1,1,1,1,0,1, 0,0,1,0, 16'd4, 16'd2);
        cyc("rw_done",     1,0,0,0,0,0, 1,0,0,0, 16'd4, 16'd2);

        // Fetch stall counter saturation from 0xFFFE
        force dut.u_istall.count_r = 16'hFFFE;
        #1;
        release dut.u_istall.count_r;
        cyc("sat0",        0,0,0,0,0,0, 1,0,0,0, 16'd4, 16'hFFFE);
        for (int k = 0; k < 4; k++) begin
            cyc("sat_max",  0,0,0,0,0,0, 1,0,0,0, 16'd4, 16'hFFFF);
        end
        cyc("sat_hold",    1,0,0,0,0,0, 1,0,0,0, 16'd4, 16'hFFFF);

        // Reset asserted mid-DATA drops the request without a clock edge
        cyc("rst_req",     1,0,1,0,0,0, 1,0,0,0, 16'd4, 16'hFFFF);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("rst_data", 1'b0, 1'b1, 1'b0, 1'b0, 16'd4, 16'hFFFF);
        @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        expect_out("rst_async", 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        -> async_ev;
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Halt in FETCH, then HALTED holds for 100 cycles of arbitrary inputs
        cyc("halt_req",    1,0,0,0,1,0, 1,0,0,0, 16'd0, 16'd0);
        for (int k = 0; k < 100; k++) begin
            r = 6'($urandom());
            cyc("halted_hold", r[0],r[1],r[2],r[3],r[4],r[5], 0,0,0,1, 16'd0, 16'd0);
        end

        RST = 1'b1;
        #3;
        RST = 1'b0;

        // Store with halt: store completes first, then HALTED
        cyc("hw_req",      1,0,0,1,1,0, 1,0,0,0, 16'd0, 16'd0);
        cyc("hw_wait",     1,0,0,1,1,0, 0,0,1,0, 16'd0, 16'd0);
        cyc("hw_hit",      1,1,0,1,1,0, 0,0,1,0, 16'd1, 16'd0);
        cyc("hw_served",   1,0,0,1,1,0, 1,0,0,0, 16'd1, 16'd0);
        cyc("hw_halted",   1,0,0,1,1,0, 0,0,0,1, 16'd1, 16'd0);
        cyc("hw_halted2",  0,0,0,1,1,1, 0,0,0,1, 16'd1, 16'd0);

        done = 1'b1;
        -> async_ev;
    end

endmodule
